// File: rtl/hazard_pkg.sv
// +--------------------------------------------------------------------+
// | hazard_pkg : shared decode constants and MD FSM encoding for the     |
// |              pipeline interlock controller.                          |
// | Revision   : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam int c_opc_msb = 31;
  localparam int c_opc_lsb = 27;
  localparam int c_rd_msb  = 26;
  localparam int c_rd_lsb  = 22;
  localparam int c_rs_msb  = 21;
  localparam int c_rs_lsb  = 17;
  localparam int c_rt_msb  = 16;
  localparam int c_rt_lsb  = 12;
  localparam int c_alu_msb = 6;
  localparam int c_alu_lsb = 2;

  localparam logic [4:0] c_op_r    = 5'b00000;
  localparam logic [4:0] c_op_addi = 5'b00101;
  localparam logic [4:0] c_op_sw   = 5'b00111;
  localparam logic [4:0] c_op_lw   = 5'b01000;
  localparam logic [4:0] c_op_bne  = 5'b00010;
  localparam logic [4:0] c_op_blt  = 5'b00110;
  localparam logic [4:0] c_op_beq  = 5'b01001;
  localparam logic [4:0] c_op_jr   = 5'b00100;
  localparam logic [4:0] c_op_led  = 5'b01011;

  localparam logic [4:0] c_alu_mult = 5'b00110;
  localparam logic [4:0] c_alu_div  = 5'b00111;
  localparam logic [3:0] c_alu_shift_hi = 4'b0010;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  // Returns {is_mult, is_div} for an opcode / ALU-op pair.
  function automatic logic [1:0] md_kind(input logic [4:0] opc, input logic [4:0] alu);
    md_kind = 2'b00;
    if (opc == c_op_r) begin
      md_kind = {alu == c_alu_mult, alu == c_alu_div};
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/insn_reg_use.sv
// +--------------------------------------------------------------------+
// | insn_reg_use : flags which register fields an instruction reads.    |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module insn_reg_use
  import hazard_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic        rs_used_o,
  output logic        rt_used_o,
  output logic        rd_used_o
);

  logic [4:0] w_opc;
  logic [4:0] w_alu;
  logic       w_unused_fields;

  assign w_opc           = insn_i[c_opc_msb:c_opc_lsb];
  assign w_alu           = insn_i[c_alu_msb:c_alu_lsb];
  assign w_unused_fields = ^{insn_i[c_rd_msb:c_alu_msb+1], insn_i[c_alu_lsb-1:0]};

  always_comb begin
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    rd_used_o = 1'b0;
    case (w_opc)
      c_op_r: begin
        rs_used_o = 1'b1;
        rt_used_o = (w_alu[4:1] != c_alu_shift_hi);
      end
      // sw store data arrives through W->M forwarding, so its rd is not a hazard.
      c_op_addi, c_op_lw, c_op_sw: rs_used_o = 1'b1;
      c_op_bne, c_op_blt, c_op_beq, c_op_led: begin
        rs_used_o = 1'b1;
        rd_used_o = 1'b1;
      end
      c_op_jr: rd_used_o = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// +--------------------------------------------------------------------+
// | hazard_stall_ctrl : F/D/X interlock for load-use, mult/div and      |
// |   taken-branch flush. Optional macro HAZARD_PERF_CNT_EN adds perf   |
// |   counter outputs.                                                  |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] fd_insn_i,
  input  logic [31:0] dx_insn_i,
  input  logic        branch_taken_i,
  input  logic        md_ready_i,
  output logic        pc_en_o,
  output logic        fd_en_o,
  output logic        dx_en_o,
  output logic        fd_nop_o,
  output logic        dx_nop_o,
  output logic        xm_nop_o,
  output logic        md_ctrl_mult_o,
  output logic        md_ctrl_div_o,
  output logic        md_busy_o,
  output logic        md_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_load_use_o,
  output logic [31:0] perf_md_ops_o
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic       w_fd_rs_used, w_fd_rt_used, w_fd_rd_used;
  logic [4:0] w_dx_opc, w_dx_alu, w_dx_rd;
  logic [1:0] w_dx_md;
  logic       w_load_use, w_busy, w_md_detect, w_md_stall;
  logic       w_unused_dx;

  insn_reg_use u_fd_use (
    .insn_i    (fd_insn_i),
    .rs_used_o (w_fd_rs_used),
    .rt_used_o (w_fd_rt_used),
    .rd_used_o (w_fd_rd_used)
  );

  assign w_dx_opc    = dx_insn_i[c_opc_msb:c_opc_lsb];
  assign w_dx_rd     = dx_insn_i[c_rd_msb:c_rd_lsb];
  assign w_dx_alu    = dx_insn_i[c_alu_msb:c_alu_lsb];
  assign w_dx_md     = md_kind(w_dx_opc, w_dx_alu);
  assign w_unused_dx = ^{dx_insn_i[c_rs_msb:c_alu_msb+1], dx_insn_i[c_alu_lsb-1:0]};

  assign w_load_use = (w_dx_opc == c_op_lw) && (w_dx_rd != 5'd0) &&
                      ((w_fd_rs_used && (fd_insn_i[c_rs_msb:c_rs_lsb] == w_dx_rd)) ||
                       (w_fd_rt_used && (fd_insn_i[c_rt_msb:c_rt_lsb] == w_dx_rd)) ||
                       (w_fd_rd_used && (fd_insn_i[c_rd_msb:c_rd_lsb] == w_dx_rd)));

  assign w_busy      = (state_q == MD_START) || (state_q == MD_WAIT);
  // Gated by reset so an in-flight op is abandoned with enables released immediately.
  assign w_md_detect = (state_q == MD_IDLE) && (w_dx_md != 2'b00) && !branch_taken_i && !reset_i;
  assign w_md_stall  = w_busy || w_md_detect;
  assign md_busy_o    = w_busy;
  assign md_timeout_o = timeout_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    timeout_d      = timeout_q;
    md_ctrl_mult_o = 1'b0;
    md_ctrl_div_o  = 1'b0;
    case (state_q)
      MD_IDLE:  if (w_md_detect) state_d = MD_START;
      MD_START: begin
        md_ctrl_mult_o = w_dx_md[1];
        md_ctrl_div_o  = w_dx_md[0];
        cnt_d          = '0;
        state_d        = MD_WAIT;
      end
      MD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (md_ready_i) begin
          state_d = MD_DONE;
        end else if (cnt_q == c_cnt_last) begin
          state_d   = MD_DONE;
          timeout_d = 1'b1;
        end
      end
      MD_DONE:  state_d = MD_IDLE;
      default:  state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    pc_en_o  = 1'b1;
    fd_en_o  = 1'b1;
    dx_en_o  = 1'b1;
    fd_nop_o = 1'b0;
    dx_nop_o = 1'b0;
    xm_nop_o = 1'b0;
    if (w_md_stall) begin
      pc_en_o  = 1'b0;
      fd_en_o  = 1'b0;
      dx_en_o  = 1'b0;
      xm_nop_o = 1'b1;
    end else if (branch_taken_i) begin
      fd_nop_o = 1'b1;
      dx_nop_o = 1'b1;
    end else if (w_load_use) begin
      pc_en_o  = 1'b0;
      fd_en_o  = 1'b0;
      dx_nop_o = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_lu_q, perf_md_q;
  logic        w_lu_fire;

  assign w_lu_fire = w_load_use && !w_md_stall && !branch_taken_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_stall_q <= '0;
      perf_lu_q    <= '0;
      perf_md_q    <= '0;
    end else begin
      if (!pc_en_o)    perf_stall_q <= perf_stall_q + 32'd1;
      if (w_lu_fire)   perf_lu_q    <= perf_lu_q + 32'd1;
      if (w_md_detect) perf_md_q    <= perf_md_q + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_load_use_o     = perf_lu_q;
  assign perf_md_ops_o       = perf_md_q;
`endif

endmodule

`default_nettype wire
